// File: rtl/spart_bus_fifo_if.sv
//------------------------------------------------------------------------------
// spart_bus_fifo_if : SPART processor bus interface with RX/TX FIFOs, TX issue
//                     FSM, readable baud divisor and extended status register.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spart_bus_fifo_if #(
    parameter int          RX_DEPTH   = 8,
    parameter int          TX_DEPTH   = 8,
    parameter logic [15:0] BAUD_RESET = 16'h0145
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iocs,
    input  logic        iorw,
    input  logic [1:0]  ioaddr,
    inout  wire  [7:0]  databus,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [15:0] baud_div,
    output logic        baud_load
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);

    localparam logic [RX_AW-1:0] C_RX_PTR_ONE = RX_AW'(1);
    localparam logic [TX_AW-1:0] C_TX_PTR_ONE = TX_AW'(1);
    localparam logic [RX_AW:0]   C_RX_CNT_ONE = (RX_AW + 1)'(1);
    localparam logic [TX_AW:0]   C_TX_CNT_ONE = (TX_AW + 1)'(1);
    localparam logic [RX_AW:0]   C_RX_FULL    = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0]   C_TX_FULL    = (TX_AW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } tx_state_t;

    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] r_rx_wr;
    logic [RX_AW-1:0] r_rx_rd;
    logic [RX_AW:0]   r_rx_count;
    logic             r_rx_ovr;

    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] r_tx_wr;
    logic [TX_AW-1:0] r_tx_rd;
    logic [TX_AW:0]   r_tx_count;

    tx_state_t        r_state;
    tx_state_t        w_next;
    logic             r_tx_start;
    logic [7:0]       r_tx_data;
    logic [15:0]      r_baud_div;
    logic             r_baud_load;

    logic       w_rd, w_wr, w_stat_rd, w_ctrl_wr;
    logic [7:0] w_wdata, w_rdata, w_status;
    logic       w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_ovr_set, w_rx_flush;
    logic       w_tx_empty, w_tx_full, w_tx_push, w_tx_launch, w_tx_flush, w_tx_idle;
    logic [4:0] w_rx_cnt_ext;
    logic [3:0] w_rx_cnt_sat;

    assign w_wdata   = databus;
    assign w_rd      = iocs && iorw;
    assign w_wr      = iocs && !iorw;
    assign w_stat_rd = w_rd && (ioaddr == 2'd1);
    assign w_ctrl_wr = w_wr && (ioaddr == 2'd1);

    assign w_rx_empty   = (r_rx_count == '0);
    assign w_rx_full    = (r_rx_count == C_RX_FULL);
    assign w_rx_flush   = w_ctrl_wr && w_wdata[0];
    assign w_rx_pop     = w_rd && (ioaddr == 2'd0) && !w_rx_empty && !w_rx_flush;
    // A pop in the same cycle frees the slot the incoming byte needs.
    assign w_rx_push    = rx_valid && (!w_rx_full || w_rx_pop) && !w_rx_flush;
    assign w_rx_ovr_set = rx_valid && w_rx_full && !w_rx_pop;

    assign w_tx_empty = (r_tx_count == '0);
    assign w_tx_full  = (r_tx_count == C_TX_FULL);
    assign w_tx_flush = w_ctrl_wr && w_wdata[1];
    assign w_tx_push  = w_wr && (ioaddr == 2'd0) && (!w_tx_full || w_tx_launch) && !w_tx_flush;
    assign w_tx_idle  = w_tx_empty && (r_state == S_IDLE);

    // RX FIFO
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_rx_flush) begin
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_rx_count <= '0;
            r_rx_ovr   <= 1'b0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr <= r_rx_wr + C_RX_PTR_ONE;
            end
            if (w_rx_pop) begin
                r_rx_rd <= r_rx_rd + C_RX_PTR_ONE;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + C_RX_CNT_ONE;
                2'b01:   r_rx_count <= r_rx_count - C_RX_CNT_ONE;
                default: r_rx_count <= r_rx_count;
            endcase
            if (w_rx_ovr_set) begin
                r_rx_ovr <= 1'b1;
            end else if (w_stat_rd) begin
                r_rx_ovr <= 1'b0;
            end
        end
    end

    // TX FIFO
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_tx_flush) begin
            r_tx_wr    <= '0;
            r_tx_rd    <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr <= r_tx_wr + C_TX_PTR_ONE;
            end
            if (w_tx_launch) begin
                r_tx_rd <= r_tx_rd + C_TX_PTR_ONE;
            end
            case ({w_tx_push, w_tx_launch})
                2'b10:   r_tx_count <= r_tx_count + C_TX_CNT_ONE;
                2'b01:   r_tx_count <= r_tx_count - C_TX_CNT_ONE;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // TX issue FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_state    <= w_next;
            r_tx_start <= w_tx_launch;
            if (w_tx_launch) begin
                r_tx_data <= r_tx_mem[r_tx_rd];
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_tx_launch = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_tx_empty && tx_ready && !w_tx_flush) begin
                    w_next      = S_WAIT_BUSY;
                    w_tx_launch = 1'b1;
                end
            end
            // The transmitter may still report ready while it latches the strobe.
            S_WAIT_BUSY: w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (tx_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Baud divisor
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_div  <= BAUD_RESET;
            r_baud_load <= 1'b0;
        end else begin
            r_baud_load <= w_wr && ioaddr[1];
            if (w_wr && (ioaddr == 2'd2)) begin
                r_baud_div[7:0] <= w_wdata;
            end
            if (w_wr && (ioaddr == 2'd3)) begin
                r_baud_div[15:8] <= w_wdata;
            end
        end
    end

    // Read path
    assign w_rx_cnt_ext = 5'(r_rx_count);
    assign w_rx_cnt_sat = (w_rx_cnt_ext > 5'd15) ? 4'hF : w_rx_cnt_ext[3:0];
    assign w_status     = {w_rx_cnt_sat, w_tx_idle, r_rx_ovr, !w_tx_full, !w_rx_empty};

    always_comb begin
        w_rdata = 8'h00;
        case (ioaddr)
            2'd0:    w_rdata = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd];
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata = r_baud_div[7:0];
            default: w_rdata = r_baud_div[15:8];
        endcase
    end

    assign databus   = w_rd ? w_rdata : 8'bz;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign baud_div  = r_baud_div;
    assign baud_load = r_baud_load;

endmodule

`default_nettype wire

// File: tb/tb_spart_bus_fifo_if.sv
//------------------------------------------------------------------------------
// tb_spart_bus_fifo_if : directed and randomized bench for spart_bus_fifo_if
//                        against a queue-based reference model.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spart_bus_fifo_if;

    localparam int          RXD = 8;
    localparam int          TXD = 8;
    localparam logic [15:0] BR  = 16'h0145;

    logic        clk = 1'b0;
    logic        rst, iocs, iorw, rx_valid, tx_ready;
    logic [1:0]  ioaddr;
    logic [7:0]  rx_data, tx_data;
    logic        tx_start, baud_load;
    logic [15:0] baud_div;
    wire  [7:0]  databus;
    logic        drv;
    logic [7:0]  dout;

    assign databus = drv ? dout : 8'bz;

    spart_bus_fifo_if #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .BAUD_RESET(BR)) dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_start(tx_start),
        .baud_div(baud_div), .baud_load(baud_load)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, transmitter engine as busy flag.
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    bit          m_ovr, m_busy, m_tx_start, m_load;
    int          m_grace;
    logic [15:0] m_baud;
    logic [7:0]  m_tx_data;

    // Behavioural transmitter driving tx_ready.
    bit xr_ready = 1'b1;
    int xr_cnt   = 0;
    bit hold_low = 1'b0;

    task automatic model_reset();
        rx_q.delete();
        tx_q.delete();
        m_ovr = 0; m_busy = 0; m_grace = 0; m_tx_start = 0; m_load = 0;
        m_baud = BR; m_tx_data = 8'h00;
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] a);
        int c;
        c = (rx_q.size() > 15) ? 15 : rx_q.size();
        case (a)
            2'd0:    return (rx_q.size() > 0) ? rx_q[0] : 8'h00;
            2'd1:    return {4'(c), (tx_q.size() == 0) && !m_busy, m_ovr,
                             tx_q.size() < TXD, rx_q.size() > 0};
            2'd2:    return m_baud[7:0];
            default: return m_baud[15:8];
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit cs, input bit rw, input logic [1:0] a,
                              input logic [7:0] d, input bit rv, input logic [7:0] rdat,
                              input bit rdy);
        bit rdq, wrq, pop, rxf, txf, novr, launch, txpush;
        if (r) begin
            model_reset();
            return;
        end
        rdq    = cs && rw;
        wrq    = cs && !rw;
        rxf    = wrq && (a == 2'd1) && d[0];
        txf    = wrq && (a == 2'd1) && d[1];
        pop    = rdq && (a == 2'd0) && (rx_q.size() > 0);
        novr   = rv && (rx_q.size() == RXD) && !pop;
        launch = !m_busy && (tx_q.size() > 0) && rdy && !txf;
        txpush = wrq && (a == 2'd0) && ((tx_q.size() < TXD) || launch);

        if (rxf) begin
            rx_q.delete();
            m_ovr = 0;
        end else begin
            if (pop) void'(rx_q.pop_front());
            if (rv && !novr) rx_q.push_back(rdat);
            if (novr) m_ovr = 1;
            else if (rdq && (a == 2'd1)) m_ovr = 0;
        end

        m_tx_start = launch;
        if (launch) m_tx_data = tx_q.pop_front();
        if (txf) tx_q.delete();
        else if (txpush) tx_q.push_back(d);

        if (launch) begin
            m_busy = 1; m_grace = 1;
        end else if (m_busy) begin
            if (m_grace > 0) m_grace--;
            else if (rdy) m_busy = 0;
        end

        m_load = wrq && a[1];
        if (wrq && (a == 2'd2)) m_baud[7:0]  = d;
        if (wrq && (a == 2'd3)) m_baud[15:8] = d;
    endtask

    // One bus cycle; entered and left just after a falling edge.
    task automatic cyc(input bit r, input bit cs, input bit rw, input logic [1:0] a,
                       input logic [7:0] d, input bit rv, input logic [7:0] rdat);
        logic [7:0] exp_rd;
        rst = r; iocs = cs; iorw = rw; ioaddr = a; dout = d; drv = cs && !rw;
        rx_valid = rv; rx_data = rdat;
        tx_ready = hold_low ? 1'b0 : xr_ready;
        #1;
        if (cs && rw) begin
            exp_rd = model_read(a);
            check($sformatf("read_a%0d", a), {8'h00, databus}, {8'h00, exp_rd});
        end
        @(posedge clk);
        model_edge(r, cs, rw, a, d, rv, rdat, tx_ready);
        #1;
        check("tx_start",  {15'h0, tx_start},  {15'h0, m_tx_start});
        check("tx_data",   {8'h00, tx_data},   {8'h00, m_tx_data});
        check("baud_div",  baud_div,           m_baud);
        check("baud_load", {15'h0, baud_load}, {15'h0, m_load});
        if (tx_start) begin
            xr_ready = 1'b0;
            xr_cnt   = $urandom_range(1, 4);
        end else if (xr_cnt > 0) begin
            xr_cnt--;
            if (xr_cnt == 0) xr_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, d, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(1'b0, 1'b1, 1'b1, a, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic rxb(input logic [7:0] b);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, b);
    endtask

    initial begin
        bit         r, cs, rw, rv;
        logic [1:0] a;
        logic [7:0] d;

        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0; drv = 1'b0; dout = 8'h00;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        model_reset();
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00);

        // Reset state: status, divisor, empty RX read
        rd(2'd1);
        check("reset_status", {8'h00, model_read(2'd1)}, 16'h000A);
        rd(2'd0);
        rd(2'd0);

        // Two transmissions
        wr(2'd0, 8'hA5);
        wr(2'd0, 8'h3C);
        idle(14);
        rd(2'd1);

        // RX overrun, drain, status clear
        for (int i = 1; i <= 9; i++) rxb(8'(i));
        rd(2'd1);
        for (int i = 0; i < 8; i++) rd(2'd0);
        rd(2'd1);

        // Full RX with simultaneous pop and push
        for (int i = 0; i < 8; i++) rxb(8'h10 + 8'(i));
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 8'h55);
        rd(2'd1);
        wr(2'd1, 8'h01);
        rd(2'd1);

        // Baud divisor writes and readback
        wr(2'd2, 8'h80);
        wr(2'd3, 8'h01);
        idle(1);
        rd(2'd2);
        rd(2'd3);

        // TX full, drop, flush
        hold_low = 1'b1;
        idle(8);
        for (int i = 0; i < 9; i++) wr(2'd0, 8'hC0 + 8'(i));
        rd(2'd1);
        wr(2'd1, 8'h02);
        rd(2'd1);
        hold_low = 1'b0;

        // Reset in the middle of a transmission
        idle(6);
        wr(2'd0, 8'h77);
        wr(2'd0, 8'h78);
        idle(1);
        wr(2'd2, 8'h11);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
        rd(2'd1);
        idle(4);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ((n % 250) == 0) hold_low = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 599) == 0);
            cs = ($urandom_range(0, 99) < 60);
            rw = $urandom_range(0, 1) == 1;
            a  = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            if (cs && !rw && (a == 2'd1)) d = ($urandom_range(0, 9) == 0) ? (d & 8'h03) : 8'h00;
            rv = ($urandom_range(0, 99) < 35);
            cyc(r, cs, rw, a, d, rv, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
